score_argmax_reader: RTL and testbench

SCORE_ARGMAX_READER -- requirements
Module: score_argmax_reader

---
 rtl/lenet_pkg.sv | 20 ++
 rtl/max4_signed.sv | 51 +++++
 rtl/score_argmax_reader.sv | 147 ++++++++++++++
 tb/tb_score_argmax_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lenet_pkg
// Description : Shared LeNet constants and the FC2 score-reader FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lenet_pkg;

  localparam int SCORE_NUM       = 10;
  localparam int SRAM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } argmax_state_e;

endpackage
`default_nettype wire

// File: rtl/max4_signed.sv
`default_nettype none
// ============================================================================
// Module      : max4_signed
// Description : Combinational 4-input signed maximum. On equal values the
//               lower lane wins. Returns the value and its 2-bit lane index.
// Revision    : 1.0 - initial release
// ============================================================================
module max4_signed #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] i_in0,
  input  logic signed [DATA_WIDTH-1:0] i_in1,
  input  logic signed [DATA_WIDTH-1:0] i_in2,
  input  logic signed [DATA_WIDTH-1:0] i_in3,
  output logic signed [DATA_WIDTH-1:0] o_max_val,
  output logic        [1:0]            o_max_idx
);

  logic signed [DATA_WIDTH-1:0] w_lo_val;
  logic signed [DATA_WIDTH-1:0] w_hi_val;
  logic        [1:0]            w_lo_idx;
  logic        [1:0]            w_hi_idx;

  // Pairwise tree; the higher lane only wins when strictly greater, and the
  // low pair always holds lower indices, so ties resolve to the lowest lane.
  always_comb begin
    w_lo_val  = i_in0;
    w_lo_idx  = 2'd0;
    w_hi_val  = i_in2;
    w_hi_idx  = 2'd2;
    o_max_val = i_in0;
    o_max_idx = 2'd0;
    if (i_in1 > i_in0) begin
      w_lo_val = i_in1;
      w_lo_idx = 2'd1;
    end
    if (i_in3 > i_in2) begin
      w_hi_val = i_in3;
      w_hi_idx = 2'd3;
    end
    if (w_hi_val > w_lo_val) begin
      o_max_val = w_hi_val;
      o_max_idx = w_hi_idx;
    end else begin
      o_max_val = w_lo_val;
      o_max_idx = w_lo_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/score_argmax_reader.sv
`default_nettype none
// ============================================================================
// Module      : score_argmax_reader
// Description : Reads the packed FC2 class scores from SRAM f after fc2_done,
//               finds the signed maximum (lowest index on ties) and offers
//               the winning class id/score on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module score_argmax_reader
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH             = 8,
  parameter int SCORE_NUM              = lenet_pkg::SCORE_NUM,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  fc2_done,
  output logic [9:0]            sram_raddr_f,
  input  logic [31:0]           sram_rdata_f,
  output logic                  class_valid,
  input  logic                  class_ready,
  output logic [3:0]            class_id,
  output logic [DATA_WIDTH-1:0] class_score,
  output logic                  busy
);

  localparam int c_word_num = (SCORE_NUM + DATA_NUM_PER_SRAM_ADDR - 1) / DATA_NUM_PER_SRAM_ADDR;
  localparam logic [9:0] c_last_addr = 10'(c_word_num - 1);
  localparam logic signed [DATA_WIDTH-1:0] c_most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  argmax_state_e r_state;
  argmax_state_e w_state_nxt;

  logic [9:0]                   r_cnt;
  logic signed [DATA_WIDTH-1:0] r_max;
  logic [3:0]                   r_idx;

  logic                         w_start;
  logic                         w_fold;
  logic [9:0]                   w_word;
  logic [11:0]                  w_base;
  logic signed [DATA_WIDTH-1:0] w_lane_val [4];
  logic signed [DATA_WIDTH-1:0] w_blk_max;
  logic [1:0]                   w_blk_lane;
  logic [3:0]                   w_cand_idx;

  // A run only launches from IDLE, so fc2_done while busy is dropped.
  assign w_start = (r_state == ST_IDLE) && fc2_done;

  // Read data lags the address by one cycle: fold from the second READ cycle
  // onwards, and once more in DRAIN for the last word.
  assign w_fold = ((r_state == ST_READ) && (r_cnt != 10'd0)) || (r_state == ST_DRAIN);
  assign w_word = (r_state == ST_DRAIN) ? c_last_addr : (r_cnt - 10'd1);
  assign w_base = {w_word, 2'b00};

  // Lane k holds score base+k in the k-th byte from the top; lanes past the
  // last real score are forced to the most negative value so they never win.
  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      assign w_lane_val[k] = ((w_base + 12'(k)) < 12'(SCORE_NUM))
                           ? sram_rdata_f[SRAM_DATA_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH]
                           : c_most_neg;
    end
  endgenerate

  max4_signed #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_max4 (
    .i_in0     (w_lane_val[0]),
    .i_in1     (w_lane_val[1]),
    .i_in2     (w_lane_val[2]),
    .i_in3     (w_lane_val[3]),
    .o_max_val (w_blk_max),
    .o_max_idx (w_blk_lane)
  );

  assign w_cand_idx = w_base[3:0] + {2'b00, w_blk_lane};

  // State register.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/address outputs.
  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b1;
    class_valid  = 1'b0;
    sram_raddr_f = 10'd0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (fc2_done) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        sram_raddr_f = r_cnt;
        if (r_cnt == c_last_addr) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        class_valid = 1'b1;
        if (class_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address counter: steps once per READ cycle, otherwise parked at 0.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_cnt <= 10'd0;
    end else if ((r_state == ST_READ) && (r_cnt != c_last_addr)) begin
      r_cnt <= r_cnt + 10'd1;
    end else begin
      r_cnt <= 10'd0;
    end
  end

  // Running max/index: cleared on launch, replaced only on a strictly
  // greater block maximum so earlier (lower) indices win ties.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_max <= '0;
      r_idx <= 4'd0;
    end else if (w_start) begin
      r_max <= c_most_neg;
      r_idx <= 4'd0;
    end else if (w_fold && (w_blk_max > r_max)) begin
      r_max <= w_blk_max;
      r_idx <= w_cand_idx;
    end
  end

  assign class_id    = r_idx;
  assign class_score = r_max;

endmodule
`default_nettype wire

// File: tb/tb_score_argmax_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_argmax_reader
// Description : Self-checking bench for score_argmax_reader with an SRAM
//               model and an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_argmax_reader;

  logic        clk = 1'b0;
  logic        srstn;
  logic        fc2_done;
  logic [9:0]  sram_raddr_f;
  logic [31:0] sram_rdata_f;
  logic        class_valid;
  logic        class_ready;
  logic [3:0]  class_id;
  logic [7:0]  class_score;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]       mem [4];
  logic signed [7:0] sc  [10];
  logic [11:0]       exp_q [$];
  logic [11:0]       last_exp;

  score_argmax_reader #(
    .DATA_WIDTH             (8),
    .SCORE_NUM              (10),
    .DATA_NUM_PER_SRAM_ADDR (4)
  ) dut (
    .clk          (clk),
    .srstn        (srstn),
    .fc2_done     (fc2_done),
    .sram_raddr_f (sram_raddr_f),
    .sram_rdata_f (sram_rdata_f),
    .class_valid  (class_valid),
    .class_ready  (class_ready),
    .class_id     (class_id),
    .class_score  (class_score),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // SRAM f: one-cycle read latency.
  always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f[1:0]];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_scores(input int t [10]);
    for (int i = 0; i < 10; i++) sc[i] = 8'(t[i]);
  endtask

  task automatic load_mem(input logic [15:0] junk);
    mem[0] = {sc[0], sc[1], sc[2], sc[3]};
    mem[1] = {sc[4], sc[5], sc[6], sc[7]};
    mem[2] = {sc[8], sc[9], junk};
    mem[3] = 32'h0;
  endtask

  // Reference argmax: signed, strictly-greater replacement.
  task automatic push_exp();
    logic signed [7:0] best;
    logic [3:0]        bid;
    best = sc[0];
    bid  = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (sc[i] > best) begin
        best = sc[i];
        bid  = 4'(i);
      end
    end
    exp_q.push_back({bid, best});
  endtask

  task automatic run_and_check(input string tag);
    int n;
    logic [11:0] e;
    @(negedge clk);
    fc2_done = 1'b1;
    @(posedge clk);
    #1;
    fc2_done = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (class_valid) break;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
    last_exp = e;
    chk({tag, "_id"}, 32'(class_id), 32'(e[11:8]));
    chk({tag, "_score"}, 32'(class_score), 32'(e[7:0]));
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    class_ready = 1'b1;
    @(posedge clk);
    #1;
    class_ready = 1'b0;
    chk({tag, "_acc_valid"}, 32'(class_valid), 32'd0);
    chk({tag, "_acc_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t [10];
    srstn       = 1'b0;
    fc2_done    = 1'b0;
    class_ready = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(class_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_id", 32'(class_id), 32'd0);
    chk("rst_score", 32'(class_score), 32'd0);
    chk("rst_raddr", 32'(sram_raddr_f), 32'd0);
    @(negedge clk);
    srstn = 1'b1;

    // Mixed scores, max 12 at index 4.
    t = '{-5, 3, 7, -128, 12, 0, 1, 2, 11, -1};
    set_scores(t);
    load_mem(16'h0000);
    push_exp();
    run_and_check("mixed");
    accept("mixed");

    // All equal with junk bytes in the unused half of word 2.
    t = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    set_scores(t);
    load_mem(16'h7F7F);
    push_exp();
    run_and_check("equal");
    accept("equal");

    // All most-negative.
    t = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    set_scores(t);
    load_mem(16'h7F7F);
    push_exp();
    run_and_check("allneg");
    accept("allneg");

    // Max at the last score.
    t = '{0, -1, 100, 5, 126, -7, 3, 9, 126, 127};
    set_scores(t);
    load_mem(16'h0000);
    push_exp();
    run_and_check("last");

    // Hold with class_ready low; fc2_done pulses must be ignored.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      fc2_done = (c == 3 || c == 10) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(class_valid), 32'd1);
      chk("hold_id", 32'(class_id), 32'(last_exp[11:8]));
      chk("hold_score", 32'(class_score), 32'(last_exp[7:0]));
    end
    fc2_done = 1'b0;
    accept("hold");
    repeat (3) @(posedge clk);
    #1;
    chk("hold_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset during READ address 1, then a fresh run.
    t = '{-90, -40, -77, -12, -100, -30, -60, -3, -50, -20};
    set_scores(t);
    load_mem(16'h7F7F);
    @(negedge clk);
    fc2_done = 1'b1;
    @(posedge clk);
    #1;
    fc2_done = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_raddr1", 32'(sram_raddr_f), 32'd1);
    #2;
    srstn = 1'b0;
    #1;
    chk("rstmid_valid", 32'(class_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_raddr", 32'(sram_raddr_f), 32'd0);
    chk("rstmid_id", 32'(class_id), 32'd0);
    chk("rstmid_score", 32'(class_score), 32'd0);
    @(negedge clk);
    srstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("noresume_busy", 32'(busy), 32'd0);
    chk("noresume_valid", 32'(class_valid), 32'd0);
    push_exp();
    run_and_check("after_rst");

    // Back-to-back: handshake edge with fc2_done high must not restart.
    @(negedge clk);
    class_ready = 1'b1;
    fc2_done    = 1'b1;
    @(posedge clk);
    #1;
    class_ready = 1'b0;
    chk("b2b_valid", 32'(class_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd0);
    t = '{1, 2, 3, 4, 5, 6, 7, 50, 8, 9};
    set_scores(t);
    load_mem(16'h0000);
    push_exp();
    run_and_check("b2b_next");
    accept("b2b_next");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
